if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch front end for the pipelined MIPS-Lite core; directly upstream of decode.
- Owns the PC register and drives the instruction-memory address.
- Captures the fetched word and PC+4 into the IF/ID pipeline register.
- Honours hazard-unit stalls and branch/jump redirects from later stages; faults on a misaligned redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
stall  input  1  hazard-unit hold request; freezes PC and IF/ID
redirect_valid  input  1  taken branch/jump resolved downstream this cycle
redirect_addr  input  32  target PC for redirect
imem_addr  output  32  instruction-memory address (combinational read, data valid same cycle)
imem_rdata  input  32  instruction word at imem_addr
if_id_instr  output  32  registered instruction to decode
if_id_pc_incr  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
fault  output  1  sticky misaligned-redirect flag
fetch_count  output  32  number of instructions latched into IF/ID

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc_incr=0, if_id_valid=0, fault=0, fetch_count=0.
- imem_addr = pc at all times (combinational from PC register).
- State machine: BOOT, RUN, FAULT.
- BOOT:
  - Exactly one cycle after rst deasserts.
  - No IF/ID capture; PC unchanged.
  - Inputs ignored; next state RUN.
- RUN, per rising edge, priority redirect > stall > advance:
  - redirect_valid=1 with redirect_addr[1:0]==0:
    - pc<=redirect_addr.
    - IF/ID flushed: if_id_instr<=NOP_INSTR, if_id_valid<=0, if_id_pc_incr<=0.
    - fetch_count unchanged.
    - Applies even if stall=1 (redirect overrides stall).
  - redirect_valid=1 with redirect_addr[1:0]!=0:
    - state<=FAULT, fault<=1, pc unchanged.
    - IF/ID flushed as above.
  - stall=1 (no redirect): pc, IF/ID and fetch_count all hold their values.
  - Otherwise (advance):
    - if_id_instr<=imem_rdata, if_id_pc_incr<=pc+4, if_id_valid<=1.
    - pc<=pc+4; fetch_count<=fetch_count+1.
- Arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
  - fetch_count wraps 32'hFFFF_FFFF to 0.
- FAULT:
  - Terminal; pc and fetch_count frozen; if_id_valid held 0; fault held 1.
  - stall and redirect ignored; exit only via rst.
- Reset mid-operation: asynchronous clear regardless of state or pending stall/redirect; BOOT cycle repeats after release.
- PC register invariant: pc[1:0] always 0.
- All outputs are registered except imem_addr, which is a direct copy of the PC register.

Test Plan:
- Reset release, imem returns addr-based words, no stall -> BOOT cycle with if_id_valid=0; then if_id_pc_incr = 4, 8, 12; if_id_instr matches words at 0, 4, 8; fetch_count = 1, 2, 3.
- Stall held 3 cycles mid-stream at pc=0x10 -> pc, if_id_instr, if_id_pc_incr and fetch_count unchanged for 3 edges; resumes with if_id_pc_incr=0x14.
- redirect_valid=1, redirect_addr=0x100, stall=1 simultaneously -> next edge: pc=0x100, if_id_valid=0, if_id_instr=NOP; following edge latches word@0x100 with if_id_pc_incr=0x104.
- RESET_PC=32'hFFFF_FFFC -> first advance gives if_id_pc_incr=0, and pc wraps to 0.
- redirect_addr=0x102 -> fault=1, pc frozen, if_id_valid=0; later redirects and stalls have no effect; rst=0 clears fault and restores pc=RESET_PC.
- rst asserted asynchronously between clock edges while if_id_valid=1 -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage: instruction-fetch front end of the MIPS-Lite pipeline.
//
// Owns the program counter, presents it to instruction memory, and captures
// the fetched word together with PC+4 into the IF/ID pipeline register.
// Downstream redirects take priority over hazard stalls; a redirect to a
// non-word-aligned target parks the stage in a terminal FAULT state.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous, active-low reset
//   stall           hazard-unit hold; freezes PC and IF/ID
//   redirect_valid  taken branch/jump resolved downstream this cycle
//   redirect_addr   redirect target PC
//   imem_addr       instruction-memory address (copy of the PC register)
//   imem_rdata      instruction word at imem_addr, valid in the same cycle
//   if_id_instr     registered instruction handed to decode
//   if_id_pc_incr   registered PC+4 of that instruction
//   if_id_valid     IF/ID holds a real instruction
//   fault           sticky misaligned-redirect flag
//   fetch_count     number of instructions latched into IF/ID
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_incr,
    output logic        if_id_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    // Low address bits are forced to zero so the PC stays word-aligned even
    // if the parameter is mis-set.
    localparam logic [XLEN-1:0] PC_RST  = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [XLEN-1:0]   pc_q,      pc_d;
    logic [XLEN-1:0]   instr_q,   instr_d;
    logic [XLEN-1:0]   pc_incr_q, pc_incr_d;
    logic              valid_q,   valid_d;
    logic              fault_q,   fault_d;
    logic [XLEN-1:0]   count_q,   count_d;

    logic [XLEN-1:0]   pc_next;
    logic              redirect_aligned;

    // Sequential PC successor; wraps modulo 2^32 naturally.
    assign pc_next          = pc_q + PC_STEP;
    assign redirect_aligned = (redirect_addr[1:0] == 2'b00);

    // State and pipeline register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= PC_RST;
            instr_q   <= NOP_INSTR;
            pc_incr_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_incr_q <= pc_incr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
        end
    end

    // Next-state and datapath selection: redirect > stall > advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_incr_d = pc_incr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        count_d   = count_q;

        unique case (state_q)
            // Single settling cycle after reset release; inputs ignored.
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    // Flush IF/ID whether or not the target is usable.
                    instr_d   = NOP_INSTR;
                    pc_incr_d = '0;
                    valid_d   = 1'b0;
                    if (redirect_aligned) begin
                        pc_d = redirect_addr;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (!stall) begin
                    instr_d   = imem_rdata;
                    pc_incr_d = pc_next;
                    valid_d   = 1'b1;
                    pc_d      = pc_next;
                    count_d   = count_q + XLEN'(1);
                end
            end

            // Terminal until reset; everything frozen.
            FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr     = pc_q;
    assign if_id_instr   = instr_q;
    assign if_id_pc_incr = pc_incr_q;
    assign if_id_valid   = valid_q;
    assign fault         = fault_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] TB_NOP   = 32'h0000_0020;
    localparam logic [31:0] WRAP_RST = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_addr, imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc_incr, fetch_count;
    logic        if_id_valid, fault;

    // Wrap-around DUT (RESET_PC = FFFF_FFFC)
    logic        rst1;
    logic [31:0] imem_addr1, imem_rdata1, instr1, incr1, count1;
    logic        valid1, fault1;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata1 = mem_word(imem_addr1);

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(TB_NOP)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc_incr(if_id_pc_incr), .if_id_valid(if_id_valid),
        .fault(fault), .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(WRAP_RST), .NOP_INSTR(TB_NOP)) dut1 (
        .clk(clk), .rst(rst1), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_addr(32'h0), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .if_id_instr(instr1), .if_id_pc_incr(incr1), .if_id_valid(valid1),
        .fault(fault1), .fetch_count(count1)
    );

    // Reference model of dut0: phase 0 = boot cycle, 1 = running, 2 = faulted.
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_incr, m_count;
    logic        m_valid, m_fault;

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0;
        m_instr = TB_NOP;
        m_incr  = 32'h0;
        m_count = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    // Drive inputs, take one rising edge, apply the fetch rules, settle.
    task automatic step(input logic s, input logic rv, input logic [31:0] ra);
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(posedge clk);
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rv) begin
                m_instr = TB_NOP;
                m_incr  = 32'h0;
                m_valid = 1'b0;
                if (ra % 4 == 0) m_pc = ra;
                else begin
                    m_phase = 2;
                    m_fault = 1'b1;
                end
            end else if (!s) begin
                m_instr = mem_word(m_pc);
                m_incr  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_count = m_count + 32'd1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count} !==
            {32'h0, TB_NOP, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state: got pc=%h instr=%h incr=%h v=%b f=%b cnt=%h", imem_addr,
                     if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count);
        end
        total++;
        if ({imem_addr1, valid1, fault1, count1} !== {WRAP_RST, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state_wrapdut: got pc=%h v=%b f=%b cnt=%h expected pc=%h",
                     imem_addr1, valid1, fault1, count1, WRAP_RST);
        end
    endtask

    task automatic test_sequential();
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({imem_addr, if_id_valid, fetch_count} !== {32'h0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL boot_cycle: got pc=%h v=%b cnt=%h expected pc=0 v=0 cnt=0",
                     imem_addr, if_id_valid, fetch_count);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            total++;
            if ({if_id_instr, if_id_pc_incr, if_id_valid, fetch_count} !==
                {mem_word(32'(4 * (i - 1))), 32'(4 * i), 1'b1, 32'(i)}) begin
                bad++;
                $display("FAIL seq_fetch_%0d: got instr=%h incr=%h v=%b cnt=%h expected incr=%h cnt=%0d",
                         i, if_id_instr, if_id_pc_incr, if_id_valid, fetch_count, 32'(4 * i), i);
            end
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            total++;
            if ({imem_addr, if_id_instr, if_id_pc_incr, fetch_count} !==
                {32'h10, mem_word(32'hC), 32'h10, 32'd4}) begin
                bad++;
                $display("FAIL stall_hold_%0d: got pc=%h instr=%h incr=%h cnt=%h expected pc=10 incr=10 cnt=4",
                         i, imem_addr, if_id_instr, if_id_pc_incr, fetch_count);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({if_id_instr, if_id_pc_incr, fetch_count} !== {mem_word(32'h10), 32'h14, 32'd5}) begin
            bad++;
            $display("FAIL stall_resume: got instr=%h incr=%h cnt=%h expected incr=14 cnt=5",
                     if_id_instr, if_id_pc_incr, fetch_count);
        end
    endtask

    task automatic test_redirect_over_stall();
        step(1'b1, 1'b1, 32'h100);
        total++;
        if ({imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fetch_count} !==
            {32'h100, TB_NOP, 32'h0, 1'b0, 32'd5}) begin
            bad++;
            $display("FAIL redirect_flush: got pc=%h instr=%h incr=%h v=%b cnt=%h expected pc=100 instr=%h",
                     imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fetch_count, TB_NOP);
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({if_id_instr, if_id_pc_incr, if_id_valid, fetch_count} !==
            {mem_word(32'h100), 32'h104, 1'b1, 32'd6}) begin
            bad++;
            $display("FAIL redirect_target_fetch: got instr=%h incr=%h v=%b cnt=%h expected incr=104",
                     if_id_instr, if_id_pc_incr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic        s, rv;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) == 0);
            ra = $urandom();
            ra[1:0] = 2'b00;
            step(s, rv, ra);
            total++;
            if ({imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count} !==
                {m_pc, m_instr, m_incr, m_valid, m_fault, m_count}) begin
                bad++;
                $display("FAIL random_%0d: got pc=%h instr=%h incr=%h v=%b f=%b cnt=%h expected pc=%h instr=%h incr=%h v=%b f=%b cnt=%h",
                         i, imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count,
                         m_pc, m_instr, m_incr, m_valid, m_fault, m_count);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 32'h0);
        total++;
        if (if_id_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_precondition: got valid=%b expected 1", if_id_valid);
        end
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count} !==
            {32'h0, TB_NOP, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL async_reset_immediate: got pc=%h instr=%h incr=%h v=%b f=%b cnt=%h",
                     imem_addr, if_id_instr, if_id_pc_incr, if_id_valid, fault, fetch_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({imem_addr, if_id_valid, fetch_count} !== {32'h0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL async_reboot: got pc=%h v=%b cnt=%h expected pc=0 v=0 cnt=0",
                     imem_addr, if_id_valid, fetch_count);
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({if_id_pc_incr, fetch_count} !== {32'h4, 32'd1}) begin
            bad++;
            $display("FAIL async_first_fetch: got incr=%h cnt=%h expected 4 1", if_id_pc_incr, fetch_count);
        end
    endtask

    task automatic test_fault();
        logic [31:0] pc_before, cnt_before, ra;
        step(1'b0, 1'b0, 32'h0);
        pc_before  = m_pc;
        cnt_before = m_count;
        step(1'b0, 1'b1, 32'h102);
        total++;
        if ({fault, if_id_valid, imem_addr, fetch_count, if_id_instr} !==
            {1'b1, 1'b0, pc_before, cnt_before, TB_NOP}) begin
            bad++;
            $display("FAIL fault_entry: got f=%b v=%b pc=%h cnt=%h instr=%h expected pc=%h cnt=%h",
                     fault, if_id_valid, imem_addr, fetch_count, if_id_instr, pc_before, cnt_before);
        end
        for (int i = 0; i < 20; i++) begin
            ra = $urandom();
            if (i % 2 == 0) ra[1:0] = 2'b00;
            step(1'(i % 3 == 0), 1'(i % 2), ra);
            total++;
            if ({imem_addr, if_id_valid, fault, fetch_count} !== {pc_before, 1'b0, 1'b1, cnt_before}) begin
                bad++;
                $display("FAIL fault_frozen_%0d: got pc=%h v=%b f=%b cnt=%h expected pc=%h cnt=%h",
                         i, imem_addr, if_id_valid, fault, fetch_count, pc_before, cnt_before);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({fault, imem_addr, fetch_count} !== {1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL fault_cleared: got f=%b pc=%h cnt=%h expected 0 0 0", fault, imem_addr, fetch_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({if_id_instr, if_id_pc_incr, if_id_valid, fault} !== {mem_word(32'h0), 32'h4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL fault_recovery: got instr=%h incr=%h v=%b f=%b expected incr=4 v=1 f=0",
                     if_id_instr, if_id_pc_incr, if_id_valid, fault);
        end
    endtask

    task automatic test_pc_wrap();
        rst1 = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({imem_addr1, valid1} !== {WRAP_RST, 1'b0}) begin
            bad++;
            $display("FAIL wrap_boot: got pc=%h v=%b expected pc=%h v=0", imem_addr1, valid1, WRAP_RST);
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({imem_addr1, instr1, incr1, valid1, count1} !== {32'h0, mem_word(WRAP_RST), 32'h0, 1'b1, 32'd1}) begin
            bad++;
            $display("FAIL wrap_first_fetch: got pc=%h instr=%h incr=%h v=%b cnt=%h expected pc=0 incr=0 cnt=1",
                     imem_addr1, instr1, incr1, valid1, count1);
        end
        step(1'b0, 1'b0, 32'h0);
        total++;
        if ({instr1, incr1, count1} !== {mem_word(32'h0), 32'h4, 32'd2}) begin
            bad++;
            $display("FAIL wrap_second_fetch: got instr=%h incr=%h cnt=%h expected incr=4 cnt=2",
                     instr1, incr1, count1);
        end
    endtask

    initial begin
        rst            = 1'b0;
        rst1           = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        model_reset();
        #12;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_random();
        test_async_reset();
        test_fault();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
